// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the multi-cycle program sequencer:
// state encoding, memory-latency bound and the HALT function alias.
package Sequencer_def;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM_WAIT,
    HALTED
  } SeqState;

  localparam int MAX_MEM_LATENCY = 7;
  localparam int WAIT_W = $clog2(MAX_MEM_LATENCY + 1);

  // Function field of the R_NEG HALT instruction in the control unit.
  localparam logic [2:0] FUN_HALT = 3'b111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;
  logic             w_full;

  assign w_full = &r_value;
  assign value  = r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc && !w_full) begin
      r_value <= r_value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter owner and fetch/execute/memory-wait sequencer
// for the 9-bit-instruction core; commit_en gates every state write.
module program_sequencer
  import Sequencer_def::*;
#(
  parameter int PC_WIDTH    = 10,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  start_addr,
  input  logic                 is_halt,
  input  logic                 ctrl_branch,
  input  logic                 take_branch,
  input  logic [7:0]           branch_target,
  input  logic                 ctrl_mem_read,
  input  logic                 ctrl_mem_write,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_en,
  output logic                 mem_en,
  output logic                 commit_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] inst_count
);

  localparam logic [WAIT_W-1:0] LAT_M1 = WAIT_W'(MEM_LATENCY - 1);
  localparam bit SINGLE_CYCLE_MEM = (MEM_LATENCY == 1);

  SeqState             r_state;
  SeqState             w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [WAIT_W-1:0]   r_wait;

  logic w_memop;
  logic w_redirect;
  logic w_start_ok;
  logic w_commit;
  logic w_mem_en;
  logic w_load_wait;
  logic w_advance;
  logic w_busy;

  assign w_memop    = ctrl_mem_read | ctrl_mem_write;
  assign w_redirect = ctrl_branch & take_branch;
  assign w_start_ok = start & ((r_state == IDLE) | (r_state == HALTED));
  assign w_busy     = (r_state == FETCH) | (r_state == EXEC) |
                      (r_state == MEM_WAIT);

  always_comb begin
    w_next      = r_state;
    w_commit    = 1'b0;
    w_mem_en    = 1'b0;
    w_load_wait = 1'b0;
    w_advance   = 1'b0;
    unique case (r_state)
      IDLE, HALTED: begin
        if (start) w_next = FETCH;
      end
      FETCH: begin
        w_next = EXEC;
      end
      EXEC: begin
        // HALT outranks everything, including a co-encoded branch.
        if (is_halt) begin
          w_commit = 1'b1;
          w_next   = HALTED;
        end else if (w_memop) begin
          w_mem_en    = 1'b1;
          w_load_wait = 1'b1;
          if (SINGLE_CYCLE_MEM) begin
            w_commit  = 1'b1;
            w_advance = 1'b1;
            w_next    = FETCH;
          end else begin
            w_next = MEM_WAIT;
          end
        end else begin
          w_commit  = 1'b1;
          w_advance = 1'b1;
          w_next    = FETCH;
        end
      end
      MEM_WAIT: begin
        w_mem_en = 1'b1;
        if (r_wait <= WAIT_W'(1)) begin
          w_commit  = 1'b1;
          w_advance = 1'b1;
          w_next    = FETCH;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_load_wait) begin
      r_wait <= LAT_M1;
    end else if (r_state == MEM_WAIT && r_wait != '0) begin
      r_wait <= r_wait - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (w_start_ok) begin
      r_pc <= start_addr;
    end else if (w_advance) begin
      r_pc <= w_redirect ? PC_WIDTH'(branch_target)
                         : r_pc + PC_WIDTH'(1);
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_ok),
    .inc   (w_busy),
    .value (cycle_count)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_inst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_ok),
    .inc   (w_commit),
    .value (inst_count)
  );

  assign pc        = r_pc;
  assign fetch_en  = (r_state == FETCH);
  assign mem_en    = w_mem_en;
  assign commit_en = w_commit;
  assign busy      = w_busy;
  assign done      = (r_state == HALTED);

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized instruction-level bench for program_sequencer with a
// per-instruction latency/PC/counter reference model.
module tb_program_sequencer;

  localparam int PW   = 10;
  localparam int LAT  = 3;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] start_addr;
  logic          is_halt;
  logic          ctrl_branch;
  logic          take_branch;
  logic [7:0]    branch_target;
  logic          ctrl_mem_read;
  logic          ctrl_mem_write;
  logic [PW-1:0] pc;
  logic          fetch_en;
  logic          mem_en;
  logic          commit_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] inst_count;

  always #5 clk = ~clk;

  program_sequencer #(
    .PC_WIDTH    (PW),
    .MEM_LATENCY (LAT),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .start_addr     (start_addr),
    .is_halt        (is_halt),
    .ctrl_branch    (ctrl_branch),
    .take_branch    (take_branch),
    .branch_target  (branch_target),
    .ctrl_mem_read  (ctrl_mem_read),
    .ctrl_mem_write (ctrl_mem_write),
    .pc             (pc),
    .fetch_en       (fetch_en),
    .mem_en         (mem_en),
    .commit_en      (commit_en),
    .busy           (busy),
    .done           (done),
    .cycle_count    (cycle_count),
    .inst_count     (inst_count)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int m_pc;
  int m_cyc;
  int m_ins;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic clr_ctrl();
    is_halt        = 1'b0;
    ctrl_branch    = 1'b0;
    take_branch    = 1'b0;
    branch_target  = 8'h00;
    ctrl_mem_read  = 1'b0;
    ctrl_mem_write = 1'b0;
  endtask

  task automatic do_start(input int a);
    start      = 1'b1;
    start_addr = PW'(a);
    @(negedge clk);
    start = 1'b0;
    m_pc  = a;
    m_cyc = 0;
    m_ins = 0;
    check("start_fetch", fetch_en, 1);
    check("start_pc", pc, a);
    check("start_cyc_clr", cycle_count, 0);
    check("start_ins_clr", inst_count, 0);
    check("start_done_low", done, 0);
  endtask

  // kind: 0 alu, 1 lw, 2 sw, 3 branch, 4 lw+branch, 5 halt, 6 halt+branch
  task automatic do_inst(input int kind, input bit tk,
                         input logic [7:0] tgt);
    bit h, m, b, ok;
    int lat, mc, cyc, com, mem;
    h = (kind >= 5);
    m = (kind == 1) || (kind == 2) || (kind == 4);
    b = (kind == 3) || (kind == 4) || (kind == 6);
    is_halt        = h;
    ctrl_mem_read  = (kind == 1) || (kind == 4);
    ctrl_mem_write = (kind == 2);
    ctrl_branch    = b;
    take_branch    = tk;
    branch_target  = tgt;
    if ($urandom_range(0, 3) == 0) begin
      start      = 1'b1;
      start_addr = PW'($urandom);
    end
    cyc = 1;
    com = 0;
    mem = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (fetch_en || done || !busy) begin
        ok = fetch_en || done;
        break;
      end
      cyc++;
      com += int'(commit_en);
      mem += int'(mem_en);
    end
    if (!ok) check("inst_timeout", 0, 1);
    lat   = h ? 2 : (m ? 1 + LAT : 2);
    mc    = (m && !h) ? LAT : 0;
    m_ins = sat(m_ins + 1);
    m_cyc = sat(m_cyc + lat);
    if (!h) m_pc = (b && tk) ? int'(tgt) : (m_pc + 1) % (1 << PW);
    check("latency", cyc, lat);
    check("commits", com, 1);
    check("mem_cycles", mem, mc);
    check("pc", pc, m_pc);
    check("inst_count", inst_count, m_ins);
    check("cycle_count", cycle_count, m_cyc);
    check("done", done, h);
    if (h) clr_ctrl();
  endtask

  task automatic halted_hold();
    repeat (3) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_pc", pc, m_pc);
    check("hold_ins", inst_count, m_ins);
    check("hold_cyc", cycle_count, m_cyc);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    clr_ctrl();
    #1;
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fetch", fetch_en, 0);
    check("rst_cnt", cycle_count + inst_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // straight-line ALU code from 5
    do_start(5);
    repeat (3) do_inst(0, 1'b1, 8'h33);
    do_inst(5, 1'b0, 8'h00);
    halted_hold();

    // memory op and branches from 8
    do_start(8);
    do_inst(1, 1'b0, 8'h00);
    do_inst(3, 1'b1, 8'h40);
    do_inst(3, 1'b0, 8'h40);
    do_inst(2, 1'b0, 8'h00);
    do_inst(4, 1'b1, 8'h7f);
    do_inst(0, 1'b1, 8'h12);
    do_inst(6, 1'b1, 8'h99);
    halted_hold();

    // PC wrap, then halt with taken branch
    do_start(1023);
    do_inst(0, 1'b0, 8'h00);
    do_inst(6, 1'b1, 8'h20);

    // long random program, drives both counters into saturation
    do_start(int'($urandom_range(0, 1023)));
    for (int k = 0; k < 80; k++)
      do_inst(int'($urandom_range(0, 4)), 1'($urandom),
              8'($urandom));
    do_inst(5, 1'($urandom), 8'($urandom));
    halted_hold();

    // restart from HALTED at 3
    do_start(3);
    do_inst(0, 1'b0, 8'h00);
    do_inst(5, 1'b0, 8'h00);

    // reset during MEM_WAIT
    do_start(8);
    ctrl_mem_read = 1'b1;
    @(negedge clk);
    check("mw_exec_mem", mem_en, 1);
    @(negedge clk);
    check("mw_wait_mem", mem_en, 1);
    check("mw_no_commit", commit_en, 0);
    rst_n = 1'b0;
    #1;
    check("mrst_pc", pc, 0);
    check("mrst_busy", busy, 0);
    check("mrst_mem", mem_en, 0);
    check("mrst_commit", commit_en, 0);
    check("mrst_fetch", fetch_en, 0);
    check("mrst_cnt", cycle_count + inst_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_ctrl();
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_pc", pc, 0);
    do_start(4);
    do_inst(0, 1'b0, 8'h00);
    do_inst(5, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
